uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one uart_tx transmitter between NUM_REQ byte-stream requesters.
- Accepts bytes over per-requester valid/ready handshakes and holds the UART data byte stable.
- Generates uart_tx's edge-triggered start pulse, then waits out each frame using uart_tx_ready.
- Grants are packet-locked, so a requester keeps the transmitter until it sends a byte flagged last.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GAP_CYCLES, 4, cycles uart_start is held low after a frame completes before the next rise (minimum 2; the transmitter needs start low for 2 cycles in its idle state to re-arm its edge detector).
- TIMEOUT_CYCLES, 64, start-acknowledge watchdog limit (used only with UART_ARB_TIMEOUT_EN).

Ports:
- uart_clock  in  1  system clock.
- uart_reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_last  in  NUM_REQ  per-requester end-of-packet flag, qualified by valid.
- req_data  in  8*NUM_REQ  packed bytes; requester i uses bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept; a byte transfers when valid and ready are both high.
- uart_start  out  1  start request to the transmitter.
- uart_d_in  out  8  byte to the transmitter, stable from capture until the frame completes.
- uart_tx_ready  in  1  transmitter idle/ready status.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last owner.
- locked  out  1  a packet is in progress (last byte not yet sent).
- busy  out  1  FSM is not in IDLE.
- timeout_err  out  1  sticky watchdog flag (exists only with UART_ARB_TIMEOUT_EN).

Behaviour:
- Reset values: uart_start=0, uart_d_in=0, req_ready=0, grant_id=0, locked=0, busy=0, timeout_err=0. RR pointer resets to 0; state resets to IDLE.
- Reset mid-frame aborts the sequence immediately. uart_start drops to 0. No byte is replayed.
- FSM states: IDLE, LAUNCH, WAIT_DONE, GAP.
- IDLE:
  - If locked, only the owner is eligible.
  - Otherwise the winner is the first requester with valid set, searching from ptr upward with wrap-around.
  - req_ready is combinational: it is the winner's one-hot only when in IDLE and uart_tx_ready=1, else 0.
  - On transfer: capture the byte into uart_d_in, set grant_id, set locked=~req_last[winner], then go to LAUNCH.
  - If the owner is locked but its valid is low: stay in IDLE and keep the lock; other requesters get no grant.
- LAUNCH: uart_start=1. Stay until uart_tx_ready=0 is sampled, then set uart_start=0 and go to WAIT_DONE.
- WAIT_DONE: uart_start=0. Stay until uart_tx_ready=1, then go to GAP.
- GAP: uart_start=0. Count GAP_CYCLES, then go to IDLE.
- Pointer update: when a byte with last=1 is accepted, ptr takes (winner+1) mod NUM_REQ, applied on that transfer. The pointer does not move while locked.
- Throughput: at most one byte per frame plus GAP_CYCLES plus LAUNCH latency (about 3 cycles).
- busy=1 in every state except IDLE.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in LAUNCH.
  - If uart_tx_ready stays high for TIMEOUT_CYCLES, set timeout_err (sticky until reset), drop uart_start, clear locked, advance ptr past the owner, and go to GAP.
  - The aborted byte is discarded.
- Undefined: no counter and no timeout_err port. LAUNCH waits indefinitely.

Decomposition:
- Shared package uart_ctrl_pkg holds:
  - the arb_state_t enum {IDLE, LAUNCH, WAIT_DONE, GAP}, 2 bits;
  - the UART_BYTE_W=8 constant;
  - a MIN_START_GAP=2 constant, asserted against GAP_CYCLES.
- Sub-module rr_arbiter: purely combinational.
  - Inputs: request vector, pointer, lock, owner.
  - Outputs: one-hot grant and index.
  - Instantiated once.

Test Plan:
- Single byte: req0 sends 0xA5 with last=1. Expect req_ready[0] for 1 cycle, uart_d_in=0xA5, and one uart_start rise. The transmitter serial line shows start, 0xA5 LSB-first, stop. After GAP, busy=0.
- Round robin: all 4 requesters hold valid with last=1, bytes 0x10/0x21/0x32/0x43. Expect service order 0,1,2,3,0 and exactly one rise of uart_start per byte.
- Packet lock: req1 sends 3 bytes (last on the 3rd) while req2 stays valid throughout. Expect req1's 3 bytes to be contiguous, then req2. Also drop req1 valid for 20 cycles mid-packet; req2 must not be granted during that window.
- Gap compliance: back-to-back bytes. Check uart_start is low for at least GAP_CYCLES after uart_tx_ready rises, and that every byte is emitted (none swallowed by the transmitter's edge detector).
- Reset mid-frame: assert uart_reset low during WAIT_DONE. Expect all outputs at reset values on the next cycle and ptr=0.
- With UART_ARB_TIMEOUT_EN: tie uart_tx_ready=1. After 64 cycles in LAUNCH, expect timeout_err=1, uart_start=0, and the next requester granted.

Source files
------------

// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: shared state encoding, byte width and helpers for the uart_tx arbiter
package uart_ctrl_pkg;
  localparam int UART_BYTE_W = 8;
  localparam int MIN_START_GAP = 2;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} arb_state_t;
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 == n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick from ptr upward, or the owner alone while a packet is locked
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          lock,
  input  logic [IW-1:0] owner,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  // scan from the far end back to ptr so the nearest requester at or after ptr overwrites the rest
  always_comb begin
    gnt = '0;
    idx = lock ? owner : ptr;
    j = '0;
    if (lock) gnt[owner] = req[owner];
    else for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin sharing of one uart_tx; UART_ARB_TIMEOUT_EN adds a start-acknowledge watchdog
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                           uart_clock,
  input  logic                           uart_reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           uart_start,
  output logic [UART_BYTE_W-1:0]         uart_d_in,
  input  logic                           uart_tx_ready,
  output logic [IW-1:0]                  grant_id,
  output logic                           locked,
`ifdef UART_ARB_TIMEOUT_EN
  output logic                           timeout_err,
`endif
  output logic                           busy
);
  localparam int CW = $clog2((GAP_CYCLES > TIMEOUT_CYCLES ? GAP_CYCLES : TIMEOUT_CYCLES) + 1);
  if (GAP_CYCLES < MIN_START_GAP) begin : g_gap_chk
    $error("GAP_CYCLES must be at least MIN_START_GAP so the transmitter re-arms");
  end
  arb_state_t state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, win_idx;
  logic [NUM_REQ-1:0] win_gnt;
  logic locked_q, locked_d, xfer;
  logic [UART_BYTE_W-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
`ifdef UART_ARB_TIMEOUT_EN
  logic err_q, err_d;
  assign timeout_err = err_q;
`endif
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .lock  (locked_q),
    .owner (grant_q),
    .gnt   (win_gnt),
    .idx   (win_idx)
  );
  assign req_ready  = (state_q == IDLE && uart_tx_ready) ? win_gnt : '0;
  assign xfer       = |req_ready;
  assign uart_start = state_q == LAUNCH;
  assign uart_d_in  = data_q;
  assign grant_id   = grant_q;
  assign locked     = locked_q;
  assign busy       = state_q != IDLE;
  // sequence: accept a byte, raise start until the transmitter goes busy, wait for the frame, hold start low for the gap
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    grant_d = grant_q;
    locked_d = locked_q;
    data_d = data_q;
    cnt_d = '0;
`ifdef UART_ARB_TIMEOUT_EN
    err_d = err_q;
`endif
    case (state_q)
      IDLE: if (xfer) begin
        state_d = LAUNCH;
        data_d = req_data[{win_idx, 3'b000} +: UART_BYTE_W];
        grant_d = win_idx;
        locked_d = ~req_last[win_idx];
        if (req_last[win_idx]) ptr_d = IW'(wrap_inc(int'(win_idx), NUM_REQ));
      end
      LAUNCH: if (!uart_tx_ready) state_d = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = GAP;
        err_d = 1'b1;
        locked_d = 1'b0;
        ptr_d = IW'(wrap_inc(int'(grant_q), NUM_REQ));
      end
      else cnt_d = cnt_q + 1'b1;
`endif
      WAIT_DONE: if (uart_tx_ready) state_d = GAP;
      GAP: if (cnt_q == CW'(GAP_CYCLES - 1)) state_d = IDLE;
           else cnt_d = cnt_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any frame in flight
  always_ff @(posedge uart_clock or negedge uart_reset) begin
    if (!uart_reset) begin
      state_q <= IDLE;
      ptr_q <= '0;
      grant_q <= '0;
      locked_q <= 1'b0;
      data_q <= '0;
      cnt_q <= '0;
`ifdef UART_ARB_TIMEOUT_EN
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      locked_q <= locked_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
`ifdef UART_ARB_TIMEOUT_EN
      err_q <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of uart_tx_arbiter against a small transmitter and requester model
module tb_uart_tx_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic uart_start, tx_ready, locked, busy;
  logic [7:0] uart_d_in;
  logic [1:0] grant_id;
`ifdef UART_ARB_TIMEOUT_EN
  logic timeout_err;
`endif
  logic [8:0] mem [N][32];
  int n [N];
  int rd [N];
  logic [N-1:0] hold = '0;
  logic tie_ready = 1'b0;
  logic [7:0] tx_log [$];
  int acc_log [$];
  int rdy_cycles, swallowed, busy_cnt, low_cnt;
  int min_gap = 99;
  logic prev_start;
  int checks, errors;
  logic [7:0] exp_tx [19] = '{8'hA5, 8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'hB1, 8'hB2, 8'hB3, 8'hC1,
                              8'hD1, 8'hD2, 8'hE1, 8'h77, 8'h88, 8'h99, 8'h60, 8'h61, 8'h62};
  int exp_acc [19] = '{0, 0, 1, 2, 3, 0, 1, 1, 1, 2, 1, 1, 2, 0, 1, 3, 3, 3, 3};

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .uart_clock    (clk),
    .uart_reset    (rst_n),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .uart_start    (uart_start),
    .uart_d_in     (uart_d_in),
    .uart_tx_ready (tx_ready),
    .grant_id      (grant_id),
    .locked        (locked),
`ifdef UART_ARB_TIMEOUT_EN
    .timeout_err   (timeout_err),
`endif
    .busy          (busy)
  );

  for (genvar g = 0; g < N; g++) begin : g_src
    assign req_valid[g] = (rd[g] < n[g]) && !hold[g];
    assign req_data[8*g +: 8] = mem[g][rd[g][4:0]][7:0];
    assign req_last[g] = mem[g][rd[g][4:0]][8];
  end

  // requester side: pop on handshake and log who was served
  always @(posedge clk) begin
    if (req_ready != '0) rdy_cycles <= rdy_cycles + 1;
    for (int i = 0; i < N; i++)
      if (req_valid[i] && req_ready[i]) begin
        rd[i] <= rd[i] + 1;
        acc_log.push_back(i);
      end
  end

  // transmitter model: a start rise is honoured only after start sat low for 2+ idle cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready <= 1'b1;
      busy_cnt <= 0;
      low_cnt <= 0;
      prev_start <= 1'b0;
    end else begin
      prev_start <= uart_start;
      low_cnt <= (uart_start || !tx_ready) ? 0 : low_cnt + 1;
      if (busy_cnt != 0) begin
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) tx_ready <= 1'b1;
      end else if (uart_start && !prev_start && !tie_ready) begin
        if (low_cnt >= 2) begin
          tx_ready <= 1'b0;
          busy_cnt <= 10;
          tx_log.push_back(uart_d_in);
          if (low_cnt < min_gap) min_gap <= low_cnt;
        end else swallowed <= swallowed + 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int r, input logic [7:0] d, input logic l);
    mem[r][n[r]] = {l, d};
    n[r] = n[r] + 1;
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += n[i] - rd[i];
    return s;
  endfunction

  task automatic drain(input string tag, input int budget);
    int c = 0;
    while (!(pending() == 0 && !busy && tx_ready) && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, 32'(c < budget), 32'd1);
  endtask

  task automatic check_log(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      chk($sformatf("tx_byte%0d", i), i < tx_log.size() ? 32'(tx_log[i]) : 32'hDEAD, 32'(exp_tx[i]));
      chk($sformatf("served%0d", i), i < acc_log.size() ? 32'(acc_log[i]) : 32'hDEAD, 32'(exp_acc[i]));
    end
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start", 32'(uart_start), 0);
    chk("rst_d_in", 32'(uart_d_in), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    // single byte from requester 0
    push(0, 8'hA5, 1'b1);
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    chk("t1_start", 32'(uart_start), 1);
    chk("t1_d_in", 32'(uart_d_in), 32'hA5);
    chk("t1_busy_hi", 32'(busy), 1);
    chk("t1_locked", 32'(locked), 0);
    chk("t1_ready_off", 32'(req_ready), 0);
    drain("t1_drain", 200);
    check_log(0, 0);
    chk("t1_ready_cycles", 32'(rdy_cycles), 1);
    chk("t1_busy_lo", 32'(busy), 0);
    // round robin from a fresh pointer
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    push(0, 8'h10, 1'b1);
    push(1, 8'h21, 1'b1);
    push(2, 8'h32, 1'b1);
    push(3, 8'h43, 1'b1);
    push(0, 8'h54, 1'b1);
    drain("t2_drain", 400);
    check_log(1, 5);
    // packet lock: requester 1 keeps the transmitter for three bytes
    push(1, 8'hB1, 1'b0);
    push(1, 8'hB2, 1'b0);
    push(1, 8'hB3, 1'b1);
    push(2, 8'hC1, 1'b1);
    drain("t3_drain", 400);
    check_log(6, 9);
    // owner stalls mid-packet; requester 2 must wait
    push(1, 8'hD1, 1'b0);
    push(1, 8'hD2, 1'b1);
    push(2, 8'hE1, 1'b1);
    c = 0;
    while (acc_log.size() < 11 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("t3_d1_taken", 32'(acc_log.size()), 11);
    hold[1] = 1'b1;
    repeat (45) @(negedge clk);
    chk("hold_no_grant", 32'(acc_log.size()), 11);
    chk("hold_locked", 32'(locked), 1);
    chk("hold_grant_id", 32'(grant_id), 1);
    chk("hold_idle", 32'(busy), 0);
    chk("hold_ready", 32'(req_ready), 0);
    hold[1] = 1'b0;
    drain("hold_drain", 300);
    check_log(10, 12);
    // reset while the frame is on the wire
    push(0, 8'h77, 1'b0);
    c = 0;
    while (!(busy && !uart_start && !tx_ready) && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("mid_wait_done", 32'(c < 50), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_start", 32'(uart_start), 0);
    chk("mid_d_in", 32'(uart_d_in), 0);
    chk("mid_ready", 32'(req_ready), 0);
    chk("mid_grant", 32'(grant_id), 0);
    chk("mid_locked", 32'(locked), 0);
    chk("mid_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    push(1, 8'h88, 1'b1);
    push(3, 8'h99, 1'b1);
    drain("mid_drain", 300);
    check_log(13, 15);
    // back-to-back bytes from one requester
    push(3, 8'h60, 1'b1);
    push(3, 8'h61, 1'b1);
    push(3, 8'h62, 1'b1);
    drain("b2b_drain", 300);
    check_log(16, 18);
    chk("tx_count", 32'(tx_log.size()), 19);
    chk("no_swallowed", 32'(swallowed), 0);
    chk("gap_min_ok", 32'(min_gap >= 4), 1);
`ifdef UART_ARB_TIMEOUT_EN
    // transmitter never acknowledges; watchdog drops requester 2's packet and moves on
    tie_ready = 1'b1;
    push(2, 8'hC0, 1'b0);
    push(3, 8'hD0, 1'b1);
    c = 0;
    while (!timeout_err && c < 200) begin
      @(negedge clk);
      if (uart_start) c++;
    end
    chk("to_start_cycles", 32'(c), 64);
    chk("to_err", 32'(timeout_err), 1);
    chk("to_start_low", 32'(uart_start), 0);
    chk("to_unlocked", 32'(locked), 0);
    chk("to_first", 32'(acc_log[19]), 2);
    c = 0;
    while (acc_log.size() < 21 && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk("to_next_grant", acc_log.size() > 20 ? 32'(acc_log[20]) : 32'hDEAD, 3);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
